clock_reconfig_sequencer: RTL

Sequences run-time changes of PLL clock option and CPU turbo mode for the clock generator. It accepts requested settings from the configuration registers and applies them to the generator glitch-free: CPU is frozen across PLL reconfiguration, and turbo changes land on an 8-step phase boundary. Sits between the config register file and the clock generator's `pll_option` / `turbo_enable` inputs, and drives the CPU hold line.

---
 rtl/clock_reconfig_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/clock_reconfig_sequencer.sv
// clock_reconfig_sequencer: glitch-free sequencing of PLL option and turbo mode changes with CPU hold
module clock_reconfig_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req_pll_option,
  input  logic [1:0] req_turbo,
  input  logic       pll_ready,
  input  logic       err_clr,
  output logic [2:0] pll_option,
  output logic [1:0] turbo_enable,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, DRAIN, APPLY, SETTLE, WAIT_RDY, RELEASE} state_t;
  localparam logic [15:0] SLOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TLOAD = 16'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [2:0] phase;
  logic [15:0] scnt, tcnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 3'd0;
      scnt         <= 16'd0;
      tcnt         <= 16'd0;
      pll_option   <= 3'd0;
      turbo_enable <= 2'd0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      phase <= phase + 3'd1;
      done  <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE:
          if (req_pll_option != pll_option) begin
            state    <= DRAIN;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
          end else if (req_turbo != turbo_enable && phase == 3'd7) begin
            turbo_enable <= req_turbo;
          end
        DRAIN:
          if (phase == 3'd7) state <= APPLY;
        APPLY: begin
          pll_option   <= req_pll_option;
          turbo_enable <= req_turbo;
          scnt         <= SLOAD;
          state        <= SETTLE;
        end
        SETTLE:
          if (scnt == 16'd0) begin
            state <= WAIT_RDY;
            tcnt  <= TLOAD;
          end else begin
            scnt <= scnt - 16'd1;
          end
        WAIT_RDY:
          if (pll_ready || tcnt == 16'd0) begin
            // a timeout releases the CPU anyway rather than freezing it forever
            if (!pll_ready) err <= 1'b1;
            state    <= RELEASE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else begin
            tcnt <= tcnt - 16'd1;
          end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
